// File: rtl/count_monitor_pkg.sv
// Shared definitions for the count monitor: FSM state codes and fault codes.
package count_monitor_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] err_code_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_TRACK = 2'd1;
  localparam state_t ST_FAULT = 2'd2;

  localparam err_code_t ERR_NONE = 2'b00;
  localparam err_code_t ERR_SKIP = 2'b01;
  localparam err_code_t ERR_COUT = 2'b10;
  localparam err_code_t ERR_BOTH = 2'b11;

  // Map the two independent fault conditions onto a single reported code.
  function automatic err_code_t err_code_of(input logic skip, input logic cout_flt);
    if (skip && cout_flt) return ERR_BOTH;
    if (skip)             return ERR_SKIP;
    if (cout_flt)         return ERR_COUT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Bus between the upstream counter / control and the count monitor.
interface count_monitor_if
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  CNT_I;
  logic              CNT_COUT;
  logic              EN;
  logic              CLR;
  logic [WRAP_W-1:0] WRAPS;
  logic              LOCKED;
  logic              ERR;
  err_code_t         ERR_CODE;
  logic [WIDTH-1:0]  ERR_VAL;

  modport master (
    output CNT_I, CNT_COUT, EN, CLR,
    input  WRAPS, LOCKED, ERR, ERR_CODE, ERR_VAL
  );

  modport slave (
    input  CNT_I, CNT_COUT, EN, CLR,
    output WRAPS, LOCKED, ERR, ERR_CODE, ERR_VAL
  );
endinterface

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             INC,
  output logic [width-1:0] O
);
  logic [width-1:0] cnt_q;
  logic [width-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (INC && (cnt_q != {width{1'b1}})) begin
      cnt_d = cnt_q + {{(width-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign O = cnt_q;
endmodule

// File: rtl/count_monitor.sv
// Watches an upstream counter for skipped values and carry-out mismatches,
// counts wrap-arounds, and latches the first fault until cleared.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  count_monitor_if.slave  bus
);
  state_t           state_q,  state_d;
  logic [WIDTH-1:0] prev_q,   prev_d;
  logic             err_q,    err_d;
  err_code_t        code_q,   code_d;
  logic [WIDTH-1:0] val_q,    val_d;
  logic             locked_q, locked_d;
  logic             wrap_inc;

  logic [WIDTH-1:0] expected_val;
  logic             skip;
  logic             cout_flt;

  assign expected_val = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign skip         = (bus.CNT_I != expected_val);
  assign cout_flt     = (bus.CNT_COUT != (&bus.CNT_I));

  // FSM next state, fault capture and wrap detection; CLR overrides all.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    err_d    = err_q;
    code_d   = code_q;
    val_d    = val_q;
    wrap_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.EN) begin
          prev_d  = bus.CNT_I;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!bus.EN) begin
          state_d = ST_IDLE;
        end else if (skip || cout_flt) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          code_d  = err_code_of(skip, cout_flt);
          val_d   = bus.CNT_I;
        end else begin
          prev_d   = bus.CNT_I;
          wrap_inc = bus.CNT_COUT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (bus.CLR) begin
      state_d  = ST_IDLE;
      err_d    = 1'b0;
      code_d   = ERR_NONE;
      val_d    = '0;
      wrap_inc = 1'b0;
    end
    locked_d = (state_d == ST_TRACK);
  end

  // State and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      val_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      err_q    <= err_d;
      code_q   <= code_d;
      val_q    <= val_d;
      locked_q <= locked_d;
    end
  end

  sat_counter #(.width(WRAP_W)) u_wraps (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (bus.CLR),
    .INC   (wrap_inc),
    .O     (bus.WRAPS)
  );

  assign bus.LOCKED   = locked_q;
  assign bus.ERR      = err_q;
  assign bus.ERR_CODE = code_q;
  assign bus.ERR_VAL  = val_q;
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the monitored count.
REQ-002 Parameter WRAP_W, default 8: bit width of the wrap counter.
REQ-003 The block SHALL use one clock, CLK; reset is synchronous and active-high, port RESET.
REQ-004 CLK  input  1  rising-edge clock shared with the upstream counter.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 CNT_I  input  WIDTH  count value from the upstream counter register output.
REQ-007 CNT_COUT  input  1  upstream adder carry-out; high in the same cycle CNT_I is all-ones.
REQ-008 EN  input  1  monitoring enable.
REQ-009 CLR  input  1  synchronous clear of statistics and fault.
REQ-010 WRAPS  output  WRAP_W  saturating count of observed wrap-arounds.
REQ-011 LOCKED  output  1  high while in TRACK.
REQ-012 ERR  output  1  sticky fault flag.
REQ-013 ERR_CODE  output  2  fault type: 00 none, 01 SKIP, 10 COUT, 11 BOTH.
REQ-014 ERR_VAL  output  WIDTH  CNT_I sampled in the faulting cycle.

Function
REQ-015 The block SHALL implement states IDLE, TRACK and FAULT; all outputs are registered.
REQ-016 IDLE: when EN=1, it SHALL load CNT_I into PREV and enter TRACK next cycle; no checks are made in IDLE.
REQ-017 TRACK, EN=1: expected = (PREV+1) mod 2^WIDTH; SKIP when CNT_I != expected.
REQ-018 TRACK, EN=1: COUT fault when CNT_COUT != (CNT_I == all-ones).
REQ-019 SKIP and COUT faults in the same cycle SHALL report ERR_CODE=11.
REQ-020 On any fault, the block SHALL set ERR=1, ERR_CODE and ERR_VAL on the next edge and enter FAULT; ERR latency is 1 cycle after the offending sample.
REQ-021 In a fault-free TRACK cycle, PREV SHALL be updated to CNT_I.
REQ-022 WRAPS SHALL increment by 1 in each fault-free TRACK cycle with EN=1 and CNT_COUT=1, and SHALL saturate at 2^WRAP_W-1 without rolling over.
REQ-023 EN=0 in TRACK SHALL return the block to IDLE; the next EN=1 resynchronises and no fault is raised for the gap.
REQ-024 FAULT SHALL be sticky: WRAPS, ERR_CODE and ERR_VAL are frozen and EN and CNT_I are ignored until CLR or RESET.
REQ-025 CLR=1 SHALL zero WRAPS, ERR, ERR_CODE and ERR_VAL and go to IDLE on the next edge; CLR takes priority over a fault or a wrap in the same cycle.
REQ-026 LOCKED SHALL equal 1 exactly in cycles where the registered state is TRACK.

Reset
REQ-027 RESET=1 at a clock edge SHALL force state IDLE, PREV=0, WRAPS=0, LOCKED=0, ERR=0, ERR_CODE=00 and ERR_VAL=0, and takes priority over CLR and EN.
REQ-028 Reset asserted mid-TRACK or in FAULT SHALL discard all history; after RESET deasserts, the first EN=1 cycle is a resync cycle only.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE/TRACK/FAULT) and the ERR_CODE constants (NONE/SKIP/COUT/BOTH).
REQ-030 The saturating wrap counter SHALL be a sub-module named sat_counter, with parameter width and ports CLK, RESET, CLR, INC and O.

Verification
REQ-031 Scenario 1, lock and wrap: RESET, then EN=1 driving the live counter for 40 cycles from 0 -> LOCKED=1 from cycle 2; WRAPS=2 after count 15 has passed twice; ERR=0.
REQ-032 Scenario 2, skip: in TRACK with PREV=5, force CNT_I=7 -> next cycle ERR=1, ERR_CODE=01, ERR_VAL=7, LOCKED=0; WRAPS frozen thereafter.
REQ-033 Scenario 3, carry fault and combined fault: CNT_I=15 with CNT_COUT=0 -> ERR_CODE=10. Separately, CNT_I=9 after PREV=3 with CNT_COUT=1 -> ERR_CODE=11, ERR_VAL=9.
REQ-034 Scenario 4, saturation: WRAP_W=2 and 6 wraps -> WRAPS stays at 3.
REQ-035 Scenario 5, enable gap: EN low for 3 cycles mid-count, then high -> IDLE for one cycle, then LOCKED=1; no ERR.
REQ-036 Scenario 6, priorities: CLR asserted in the same cycle as a SKIP -> ERR stays 0 and WRAPS=0. RESET and CLR together -> all reset values.
